// File: rtl/hex_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display: walks the digits
// round-robin with a blanking gap and swaps in new values only at frame boundaries.
module hex_scan_ctrl #(
    parameter int NDIGITS      = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4*NDIGITS-1:0]       value,
    input  logic                       load,
    input  logic [NDIGITS-1:0]         digit_mask,
    input  logic                       lz_en,
    output logic [3:0]                 hex,
    output logic                       en,
    output logic [NDIGITS-1:0]         an,
    output logic [$clog2(NDIGITS)-1:0] digit_idx,
    output logic                       frame_tick
);

    localparam int IW = $clog2(NDIGITS);
    localparam int CW = $clog2(DIGIT_CYCLES);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx_n;
    logic [4*NDIGITS-1:0] active, active_n, shadow;
    logic                 pending;
    logic                 last_cnt, last_idx, boundary;
    logic                 zero_above, lit, tick_n;
    logic [3:0]           nib;
    logic [NDIGITS-1:0]   an_n;

    // Outputs are computed from the next-cycle state so that the registered
    // outputs always describe the slot the counters are currently in.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_n    = state;
        active_n   = active;
        nib        = '0;
        lit        = 1'b0;
        zero_above = 1'b1;
        an_n       = '1;

        last_cnt = (cnt == CW'(DIGIT_CYCLES - 1));
        last_idx = (digit_idx == IW'(NDIGITS - 1));
        boundary = last_cnt && last_idx;

        cnt_n = last_cnt ? '0 : cnt + CW'(1);
        if (!last_cnt)     idx_n = digit_idx;
        else if (last_idx) idx_n = '0;
        else               idx_n = digit_idx + IW'(1);

        case (state)
            BLANK:   if (cnt == CW'(BLANK_CYCLES - 1)) state_n = SHOW;
            SHOW:    if (last_cnt)                     state_n = BLANK;
            default: state_n = BLANK;
        endcase

        // A load on the boundary cycle bypasses the shadow register.
        if (boundary) begin
            if (load)         active_n = value;
            else if (pending) active_n = shadow;
        end

        // Walk from the top digit down, tracking whether everything above is zero.
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (active_n[4*k +: 4] == 4'h0);
            if (idx_n == IW'(k)) begin
                nib = active_n[4*k +: 4];
                lit = digit_mask[k] && !(lz_en && zero_above && (k != 0));
            end
        end

        for (int k = 0; k < NDIGITS; k++)
            an_n[k] = !((state_n == SHOW) && lit && (idx_n == IW'(k)));

        tick_n = (cnt_n == CW'(DIGIT_CYCLES - 1)) && (idx_n == IW'(NDIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            digit_idx  <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            hex        <= 4'h0;
            en         <= 1'b0;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values regardless of statement order.
            state      <= state_n;
            cnt        <= cnt_n;
            digit_idx  <= idx_n;
            active     <= active_n;
            if (load)
                shadow <= value;
            if (boundary)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
            hex        <= nib;
            en         <= (state_n == SHOW) && lit;
            an         <= an_n;
            frame_tick <= tick_n;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: a cycle-level frame model pushes expected
// outputs into a queue at each edge and a negedge checker pops and compares them.
module tb_hex_scan_ctrl;

    localparam int ND = 4;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * DC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    digit_mask;
    logic          lz_en;
    logic [3:0]    hex;
    logic          en;
    logic [3:0]    an;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] hex;
        logic       en;
        logic [3:0] an;
        logic [1:0] idx;
        logic       ft;
    } exp_t;

    exp_t sb_q[$];

    // Bench-side frame model: a single position counter within the frame.
    int          m_cyc;
    logic [15:0] m_active, m_shadow;
    logic        m_pend;

    hex_scan_ctrl #(.NDIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .digit_mask (digit_mask),
        .lz_en      (lz_en),
        .hex        (hex),
        .en         (en),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   d, c;
        logic lz;
        if (!rst_n) begin
            m_cyc    = 0;
            m_active = 16'h0;
            m_shadow = 16'h0;
            m_pend   = 1'b0;
        end else begin
            if (m_cyc == FRAME - 1) begin
                if (load)        m_active = value;
                else if (m_pend) m_active = m_shadow;
                if (load)        m_shadow = value;
                m_pend = 1'b0;
            end else if (load) begin
                m_shadow = value;
                m_pend   = 1'b1;
            end
            m_cyc = (m_cyc + 1) % FRAME;
        end
        d = m_cyc / DC;
        c = m_cyc % DC;
        e.hex = 4'((m_active >> (4 * d)) & 16'hF);
        e.idx = 2'(d);
        e.ft  = (m_cyc == FRAME - 1);
        if (c < BC) begin
            e.en = 1'b0;
            e.an = 4'hF;
        end else begin
            lz   = lz_en && (d != 0) && ((m_active >> (4 * d)) == 16'h0);
            e.en = digit_mask[d] && !lz;
            e.an = e.en ? ~(4'b0001 << d) : 4'hF;
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_hex", 32'(hex), 32'(e.hex));
            check("sb_en", 32'(en), 32'(e.en));
            check("sb_an", 32'(an), 32'(e.an));
            check("sb_idx", 32'(digit_idx), 32'(e.idx));
            check("sb_tick", 32'(frame_tick), 32'(e.ft));
        end
    end

    // Advance at least one cycle, then until the model is at frame position target.
    task automatic goto(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (m_cyc != target && n < 3 * FRAME);
        if (m_cyc != target)
            check("goto_timeout", 32'(m_cyc), 32'(target));
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_hex [4];
        logic [3:0] exp_an  [4];
        exp_hex = '{4'hF, 4'h2, 4'hA, 4'h1};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst_n = 1'b0; load = 1'b0; value = 16'h0; digit_mask = 4'hF; lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_en", 32'(en), 32'h0);
        check("rst_hex", 32'(hex), 32'h0);
        rst_n = 1'b1;
        goto(2);
        check("first_lit_an", 32'(an), 32'hE);

        // Basic scan
        goto(5);
        pulse_load(16'h1A2F);
        goto(0);
        for (int d = 0; d < ND; d++) begin
            goto(d * DC + 1);
            check("scan_blank_an", 32'(an), 32'hF);
            goto(d * DC + 4);
            check("scan_hex", 32'(hex), 32'(exp_hex[d]));
            check("scan_an", 32'(an), 32'(exp_an[d]));
        end

        // Frame atomicity
        pulse_load(16'h1111);
        goto(DC + 3);
        pulse_load(16'h2222);
        goto(2 * DC + 4);
        check("atomic_d2_old", 32'(hex), 32'h1);
        goto(3 * DC + 4);
        check("atomic_d3_old", 32'(hex), 32'h1);
        goto(4);
        check("atomic_d0_new", 32'(hex), 32'h2);

        // Load on the frame_tick cycle
        goto(FRAME - 1);
        check("tick_seen", 32'(frame_tick), 32'h1);
        pulse_load(16'h00C3);
        goto(4);
        check("bypass_d0", 32'(hex), 32'h3);
        goto(DC + 4);
        check("bypass_d1", 32'(hex), 32'hC);

        // Leading zeros
        lz_en = 1'b1;
        goto(2 * DC + 4);
        check("lz_c3_d2_an", 32'(an), 32'hF);
        check("lz_c3_d2_en", 32'(en), 32'h0);
        goto(3 * DC + 4);
        check("lz_c3_d3_en", 32'(en), 32'h0);
        pulse_load(16'h0000);
        goto(4);
        check("lz_zero_d0_en", 32'(en), 32'h1);
        check("lz_zero_d0_hex", 32'(hex), 32'h0);
        goto(DC + 4);
        check("lz_zero_d1_en", 32'(en), 32'h0);
        pulse_load(16'h0100);
        goto(4);
        check("lz_100_d0_en", 32'(en), 32'h1);
        goto(DC + 4);
        check("lz_100_d1_en", 32'(en), 32'h1);
        goto(2 * DC + 4);
        check("lz_100_d2_en", 32'(en), 32'h1);
        goto(3 * DC + 4);
        check("lz_100_d3_en", 32'(en), 32'h0);

        // Masking
        lz_en = 1'b0;
        digit_mask = 4'b1011;
        goto(2 * DC + 4);
        check("mask_d2_an", 32'(an), 32'hF);
        goto(3 * DC + 4);
        check("mask_d3_en", 32'(en), 32'h1);

        // Reset mid-scan with a load pending
        digit_mask = 4'hF;
        goto(DC + 2);
        pulse_load(16'hABCD);
        goto(2 * DC + 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idx", 32'(digit_idx), 32'h0);
        check("midrst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        goto(DC + 4);
        check("midrst_d1_hex", 32'(hex), 32'h0);
        goto(4);
        check("midrst_next_d0", 32'(hex), 32'h0);
        goto(3 * DC + 4);
        check("midrst_next_d3", 32'(hex), 32'h0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
